// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg
//   Shared constants and helpers for the Common Data Bus arbiter.
//   - Default bus widths (tag / data).
//   - Requester indices for the round-robin group (INT, LS, DIV).
//   - Round-robin pick / pointer-advance helpers used by rr_arbiter3.
package cdb_arbiter_pkg;

  localparam int CDB_TAG_W  = 6;
  localparam int CDB_DATA_W = 32;

  // Bit positions of the round-robin requesters in the req/grant vectors.
  localparam int CDB_REQ_INT = 0;
  localparam int CDB_REQ_LS  = 1;
  localparam int CDB_REQ_DIV = 2;

  // Pointer encodings; the value 3 never occurs and is treated as INT.
  localparam logic [1:0] RR_INT = 2'd0;
  localparam logic [1:0] RR_LS  = 2'd1;
  localparam logic [1:0] RR_DIV = 2'd2;

  // First requester found when scanning INT->LS->DIV, starting at ptr.
  function automatic logic [2:0] rr_pick(input logic [2:0] req,
                                         input logic [1:0] ptr);
    logic [2:0] g;
    g = 3'b000;
    case (ptr)
      RR_LS: begin
        if      (req[CDB_REQ_LS])  g[CDB_REQ_LS]  = 1'b1;
        else if (req[CDB_REQ_DIV]) g[CDB_REQ_DIV] = 1'b1;
        else if (req[CDB_REQ_INT]) g[CDB_REQ_INT] = 1'b1;
      end
      RR_DIV: begin
        if      (req[CDB_REQ_DIV]) g[CDB_REQ_DIV] = 1'b1;
        else if (req[CDB_REQ_INT]) g[CDB_REQ_INT] = 1'b1;
        else if (req[CDB_REQ_LS])  g[CDB_REQ_LS]  = 1'b1;
      end
      default: begin
        if      (req[CDB_REQ_INT]) g[CDB_REQ_INT] = 1'b1;
        else if (req[CDB_REQ_LS])  g[CDB_REQ_LS]  = 1'b1;
        else if (req[CDB_REQ_DIV]) g[CDB_REQ_DIV] = 1'b1;
      end
    endcase
    return g;
  endfunction

  // Pointer moves to the unit after the winner; no grant keeps it.
  function automatic logic [1:0] rr_next(input logic [2:0] grant,
                                         input logic [1:0] ptr);
    logic [1:0] n;
    n = ptr;
    if (grant[CDB_REQ_INT]) n = RR_LS;
    if (grant[CDB_REQ_LS])  n = RR_DIV;
    if (grant[CDB_REQ_DIV]) n = RR_INT;
    return n;
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// rr_arbiter3
//   Three-way round-robin arbiter with a registered priority pointer.
//   Ports:
//     clk       - clock, rising edge
//     reset     - synchronous active-high reset; pointer returns to INT
//     req[2:0]  - requests, indexed INT/LS/DIV
//     en        - arbitration enable; low forces all grants to 0
//     grant[2:0]- combinational one-hot (or zero) grant
module rr_arbiter3
  import cdb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic       en,
  output logic [2:0] grant
);

  logic [1:0] r_ptr;
  logic [2:0] w_grant;

  always_comb begin
    w_grant = 3'b000;
    if (en && !reset) w_grant = rr_pick(req, r_ptr);
  end

  assign grant = w_grant;

  always_ff @(posedge clk) begin
    if (reset) r_ptr <= RR_INT;
    else       r_ptr <= rr_next(w_grant, r_ptr);
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Grants the Common Data Bus to at most one execution unit per cycle and
//   registers the winning result onto the cdb_* broadcast.
//   The multiplier cannot stall and always wins; INT/LS/DIV share the bus
//   round-robin through rr_arbiter3.
//   Ports:
//     clk, reset                 - clock, synchronous active-high reset
//     int_req/tag/data/branch/branch_taken, int_grant
//     ls_req/tag/data, ls_grant
//     div_req/tag/data, div_grant
//     mult_req/tag/data, mult_grant
//     cdb_valid/tag/data/branch/branch_taken - registered broadcast
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int TAG_W  = CDB_TAG_W,
  parameter int DATA_W = CDB_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              int_req,
  input  logic [TAG_W-1:0]  int_tag,
  input  logic [DATA_W-1:0] int_data,
  input  logic              int_branch,
  input  logic              int_branch_taken,
  output logic              int_grant,
  input  logic              ls_req,
  input  logic [TAG_W-1:0]  ls_tag,
  input  logic [DATA_W-1:0] ls_data,
  output logic              ls_grant,
  input  logic              div_req,
  input  logic [TAG_W-1:0]  div_tag,
  input  logic [DATA_W-1:0] div_data,
  output logic              div_grant,
  input  logic              mult_req,
  input  logic [TAG_W-1:0]  mult_tag,
  input  logic [DATA_W-1:0] mult_data,
  output logic              mult_grant,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data,
  output logic              cdb_branch,
  output logic              cdb_branch_taken
);

  logic [2:0]        w_rr_req;
  logic [2:0]        w_rr_grant;
  logic              w_rr_en;
  logic              w_mult_grant;

  logic              r_cdb_valid;
  logic [TAG_W-1:0]  r_cdb_tag;
  logic [DATA_W-1:0] r_cdb_data;
  logic              r_cdb_branch;
  logic              r_cdb_branch_taken;

  assign w_rr_req[CDB_REQ_INT] = int_req;
  assign w_rr_req[CDB_REQ_LS]  = ls_req;
  assign w_rr_req[CDB_REQ_DIV] = div_req;

  // A mult request suppresses the round-robin group entirely, so its
  // pointer does not move on a mult cycle.
  assign w_mult_grant = mult_req && !reset;
  assign w_rr_en      = !mult_req && !reset;

  rr_arbiter3 u_rr (
    .clk   (clk),
    .reset (reset),
    .req   (w_rr_req),
    .en    (w_rr_en),
    .grant (w_rr_grant)
  );

  assign mult_grant = w_mult_grant;
  assign int_grant  = w_rr_grant[CDB_REQ_INT];
  assign ls_grant   = w_rr_grant[CDB_REQ_LS];
  assign div_grant  = w_rr_grant[CDB_REQ_DIV];

  // Broadcast register: one result per granted cycle, cleared otherwise so
  // consumers see an all-zero bus whenever cdb_valid is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cdb_valid        <= 1'b0;
      r_cdb_tag          <= '0;
      r_cdb_data         <= '0;
      r_cdb_branch       <= 1'b0;
      r_cdb_branch_taken <= 1'b0;
    end else if (w_mult_grant) begin
      r_cdb_valid        <= 1'b1;
      r_cdb_tag          <= mult_tag;
      r_cdb_data         <= mult_data;
      r_cdb_branch       <= 1'b0;
      r_cdb_branch_taken <= 1'b0;
    end else if (w_rr_grant[CDB_REQ_INT]) begin
      r_cdb_valid        <= 1'b1;
      r_cdb_tag          <= int_tag;
      r_cdb_data         <= int_data;
      r_cdb_branch       <= int_branch;
      r_cdb_branch_taken <= int_branch_taken;
    end else if (w_rr_grant[CDB_REQ_LS]) begin
      r_cdb_valid        <= 1'b1;
      r_cdb_tag          <= ls_tag;
      r_cdb_data         <= ls_data;
      r_cdb_branch       <= 1'b0;
      r_cdb_branch_taken <= 1'b0;
    end else if (w_rr_grant[CDB_REQ_DIV]) begin
      r_cdb_valid        <= 1'b1;
      r_cdb_tag          <= div_tag;
      r_cdb_data         <= div_data;
      r_cdb_branch       <= 1'b0;
      r_cdb_branch_taken <= 1'b0;
    end else begin
      r_cdb_valid        <= 1'b0;
      r_cdb_tag          <= '0;
      r_cdb_data         <= '0;
      r_cdb_branch       <= 1'b0;
      r_cdb_branch_taken <= 1'b0;
    end
  end

  assign cdb_valid        = r_cdb_valid;
  assign cdb_tag          = r_cdb_tag;
  assign cdb_data         = r_cdb_data;
  assign cdb_branch       = r_cdb_branch;
  assign cdb_branch_taken = r_cdb_branch_taken;

  // Requesters must hold req until granted.
  a_int_hold: assert property (@(posedge clk) disable iff (reset)
    (int_req && !int_grant) |=> int_req);
  a_ls_hold: assert property (@(posedge clk) disable iff (reset)
    (ls_req && !ls_grant) |=> ls_req);
  a_div_hold: assert property (@(posedge clk) disable iff (reset)
    (div_req && !div_grant) |=> div_req);
  a_grant_onehot: assert property (@(posedge clk)
    $onehot0({mult_grant, div_grant, ls_grant, int_grant}));

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              int_req = 1'b0, int_branch = 1'b0, int_branch_taken = 1'b0;
  logic [TAG_W-1:0]  int_tag = '0, ls_tag = '0, div_tag = '0, mult_tag = '0;
  logic [DATA_W-1:0] int_data = '0, ls_data = '0, div_data = '0, mult_data = '0;
  logic              ls_req = 1'b0, div_req = 1'b0, mult_req = 1'b0;
  logic              int_grant, ls_grant, div_grant, mult_grant;
  logic              cdb_valid, cdb_branch, cdb_branch_taken;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;

  always #10 clk = ~clk;

  cdb_arbiter #(.TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .int_req(int_req), .int_tag(int_tag), .int_data(int_data),
    .int_branch(int_branch), .int_branch_taken(int_branch_taken),
    .int_grant(int_grant),
    .ls_req(ls_req), .ls_tag(ls_tag), .ls_data(ls_data), .ls_grant(ls_grant),
    .div_req(div_req), .div_tag(div_tag), .div_data(div_data), .div_grant(div_grant),
    .mult_req(mult_req), .mult_tag(mult_tag), .mult_data(mult_data),
    .mult_grant(mult_grant),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_branch(cdb_branch), .cdb_branch_taken(cdb_branch_taken)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic              v;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic              br;
    logic              tk;
  } rec_t;

  rec_t exp_q[$];

  // Requester state: units 0=INT 1=LS 2=DIV 3=MULT
  logic              pend   [4];
  logic [TAG_W-1:0]  p_tag  [4];
  logic [DATA_W-1:0] p_data [4];
  logic              p_br, p_tk;
  logic [3:0]        g_seen = 4'b0000;
  int                m_ptr  = 0;

  task automatic drive();
    int_req  = pend[0]; int_tag  = pend[0] ? p_tag[0] : '0; int_data  = pend[0] ? p_data[0] : '0;
    int_branch       = pend[0] ? p_br : 1'b0;
    int_branch_taken = pend[0] ? p_tk : 1'b0;
    ls_req   = pend[1]; ls_tag   = pend[1] ? p_tag[1] : '0; ls_data   = pend[1] ? p_data[1] : '0;
    div_req  = pend[2]; div_tag  = pend[2] ? p_tag[2] : '0; div_data  = pend[2] ? p_data[2] : '0;
    mult_req = pend[3]; mult_tag = pend[3] ? p_tag[3] : '0; mult_data = pend[3] ? p_data[3] : '0;
  endtask

  task automatic post(input int u, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d,
                      input logic br, input logic tk);
    pend[u] = 1'b1; p_tag[u] = t; p_data[u] = d;
    if (u == 0) begin p_br = br; p_tk = br & tk; end
    drive();
  endtask

  task automatic settle();
    #1;
  endtask

  // Advance one cycle: units that were granted drop their request.
  task automatic step();
    @(posedge clk);
    #2;
    for (int u = 0; u < 4; u++) if (g_seen[u]) pend[u] = 1'b0;
    drive();
    #1;
  endtask

  // Reference model: mult first, else scan from the pointer in INT,LS,DIV
  // order; the pointer lands on the unit after the winner.
  always @(negedge clk) begin : model
    logic [3:0] reqv;
    logic [3:0] eg;
    rec_t       r;
    int         pick;
    reqv = {mult_req, div_req, ls_req, int_req};
    eg   = 4'b0000;
    r    = '0;
    pick = -1;
    if (!reset) begin
      if (mult_req) pick = 3;
      else
        for (int k = 0; k < 3; k++)
          if (pick < 0 && reqv[(m_ptr + k) % 3]) pick = (m_ptr + k) % 3;
    end
    if (pick >= 0) begin
      eg[pick] = 1'b1;
      r.v = 1'b1;
      case (pick)
        0: begin r.tag = int_tag; r.data = int_data; r.br = int_branch; r.tk = int_branch_taken; end
        1: begin r.tag = ls_tag;  r.data = ls_data;  end
        2: begin r.tag = div_tag; r.data = div_data; end
        default: begin r.tag = mult_tag; r.data = mult_data; end
      endcase
      if (pick < 3) m_ptr = (pick + 1) % 3;
    end
    if (reset) m_ptr = 0;
    check("int_grant",  int_grant,  eg[0]);
    check("ls_grant",   ls_grant,   eg[1]);
    check("div_grant",  div_grant,  eg[2]);
    check("mult_grant", mult_grant, eg[3]);
    exp_q.push_back(r);
    g_seen = {mult_grant, div_grant, ls_grant, int_grant};
  end

  // Monitor: the broadcast seen after each edge must match the record
  // queued for the cycle that edge closed.
  always @(posedge clk) begin : monitor
    rec_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cdb_valid",        cdb_valid,        e.v);
      check("cdb_tag",          cdb_tag,          e.tag);
      check("cdb_data",         cdb_data,         e.data);
      check("cdb_branch",       cdb_branch,       e.br);
      check("cdb_branch_taken", cdb_branch_taken, e.tk);
    end
  end

  initial begin
    for (int u = 0; u < 4; u++) begin pend[u] = 1'b0; p_tag[u] = '0; p_data[u] = '0; end
    p_br = 1'b0; p_tk = 1'b0;
    drive();
    reset = 1'b1;
    step(); step();
    check("rst_cdb_valid", cdb_valid, 1'b0);
    check("rst_cdb_tag",   cdb_tag,   '0);

    // Single INT branch result
    reset = 1'b0;
    post(0, 6'h05, 32'hDEADBEEF, 1'b1, 1'b1); settle();
    check("t1_int_grant", int_grant, 1'b1);
    step();
    check("t1_valid", cdb_valid, 1'b1);
    check("t1_tag",   cdb_tag,   6'h05);
    check("t1_data",  cdb_data,  32'hDEADBEEF);
    check("t1_br",    cdb_branch, 1'b1);
    check("t1_tk",    cdb_branch_taken, 1'b1);
    step();
    check("t1_idle_valid", cdb_valid, 1'b0);
    check("t1_idle_tag",   cdb_tag,   '0);
    check("t1_idle_data",  cdb_data,  '0);
    check("t1_idle_br",    cdb_branch, 1'b0);

    // INT, LS, DIV together right after reset
    reset = 1'b1; step(); step(); reset = 1'b0;
    post(0, 6'd1, 32'h1111, 1'b0, 1'b0);
    post(1, 6'd2, 32'h2222, 1'b0, 1'b0);
    post(2, 6'd3, 32'h3333, 1'b0, 1'b0);
    settle();
    check("t2_int_first", int_grant, 1'b1);
    step();
    check("t2_ls_second", ls_grant, 1'b1);
    check("t2_tag1", cdb_tag, 6'd1);
    step();
    check("t2_div_third", div_grant, 1'b1);
    check("t2_tag2", cdb_tag, 6'd2);
    step();
    check("t2_tag3", cdb_tag, 6'd3);

    // Mult overrides LS
    post(3, 6'd9, 32'h9999, 1'b0, 1'b0);
    post(1, 6'd2, 32'h2020, 1'b0, 1'b0);
    settle();
    check("t3_mult_grant", mult_grant, 1'b1);
    check("t3_ls_wait",    ls_grant,   1'b0);
    step();
    check("t3_ls_grant", ls_grant, 1'b1);
    check("t3_tag9",     cdb_tag,  6'd9);
    step();
    check("t3_tag2", cdb_tag, 6'd2);

    // After a DIV grant LS beats DIV
    post(2, 6'd7, 32'h7777, 1'b0, 1'b0); settle();
    check("t4_div_alone", div_grant, 1'b1);
    step();
    post(1, 6'd4, 32'h4444, 1'b0, 1'b0);
    post(2, 6'd8, 32'h8888, 1'b0, 1'b0);
    settle();
    check("t4_ls_first", ls_grant, 1'b1);
    check("t4_div_wait", div_grant, 1'b0);
    step();
    check("t4_div_next", div_grant, 1'b1);
    step();

    // Reset mid-broadcast
    post(0, 6'h11, 32'hA1, 1'b0, 1'b0);
    post(1, 6'h12, 32'hA2, 1'b0, 1'b0);
    settle();
    step();
    post(0, 6'h13, 32'hA3, 1'b1, 1'b0);
    settle();
    check("t5_valid_before", cdb_valid, 1'b1);
    reset = 1'b1; settle();
    check("t5_rst_int", int_grant, 1'b0);
    check("t5_rst_ls",  ls_grant,  1'b0);
    step();
    check("t5_rst_valid", cdb_valid, 1'b0);
    check("t5_rst_tag",   cdb_tag,   '0);
    reset = 1'b0; settle();
    check("t5_after_int", int_grant, 1'b1);
    check("t5_after_ls",  ls_grant,  1'b0);

    // Random stress with idle phases and occasional resets
    for (int i = 0; i < 3000; i++) begin
      int lim;
      step();
      if (reset) reset = 1'b0;
      lim = ((i / 400) % 3 == 0) ? 1 : (((i / 400) % 3 == 1) ? 3 : 12);
      for (int u = 0; u < 3; u++)
        if (!pend[u] && $urandom_range(0, lim) == 0)
          post(u, 6'($urandom), $urandom, 1'($urandom), 1'($urandom));
      if ($urandom_range(0, lim + 2) == 0)
        post(3, 6'($urandom), $urandom, 1'b0, 1'b0);
      if ($urandom_range(0, 249) == 0) begin
        reset = 1'b1;
        for (int u = 0; u < 4; u++) pend[u] = 1'b0;
        drive();
      end
      settle();
    end

    reset = 1'b0;
    for (int i = 0; i < 12; i++) step();
    check("drain_valid", cdb_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
